// File: rtl/spi_regfile_sync.sv
// ---------------------------------------------------------------------------
// spi_regfile_sync
//
// System-clock-domain register bank that sits directly behind the SPI bridge.
// The bridge announces each write by flipping wr_toggle_in while holding
// wr_addr_in / wr_data_in quasi-static. This block synchronizes the toggle,
// detects its edges, and commits the write one cycle after detection into a
// 2**ADDR_W x DATA_W register array. The top two addresses are read-only:
// DEPTH-2 returns a count of committed writes and DEPTH-1 returns hw_status.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   wr_addr_in    write address from the bridge (SCLK domain, quasi-static)
//   wr_data_in    write data from the bridge (SCLK domain, quasi-static)
//   wr_toggle_in  write toggle from the bridge; every transition = one write
//   rd_addr       read address from the bridge
//   rd_data       combinational read data for rd_addr
//   hw_status     core status byte, read-only at the top address
//   reg_wr_pulse  one-cycle pulse when a write commits to the array
//   reg_wr_addr   address of the last committed or rejected write
//   reg_wr_data   data of the last committed or rejected write
//   wr_err_pulse  one-cycle pulse when a write targets a read-only address
//   regs_flat     every register; reg n at bits [n*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module spi_regfile_sync #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                wr_addr_in,
    input  logic [DATA_W-1:0]                wr_data_in,
    input  logic                             wr_toggle_in,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [DATA_W-1:0]                rd_data,
    input  logic [DATA_W-1:0]                hw_status,
    output logic                             reg_wr_pulse,
    output logic [ADDR_W-1:0]                reg_wr_addr,
    output logic [DATA_W-1:0]                reg_wr_data,
    output logic                             wr_err_pulse,
    output logic [(2**ADDR_W)*DATA_W-1:0]    regs_flat
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int CNT_ADDR   = DEPTH - 2;
    localparam int STAT_ADDR  = DEPTH - 1;
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    localparam logic [ADDR_W-1:0] CNT_ADDR_V  = ADDR_W'(CNT_ADDR);
    localparam logic [ADDR_W-1:0] STAT_ADDR_V = ADDR_W'(STAT_ADDR);

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tog_s;
    logic                   toggle_prev;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;
    logic                   wr_event;
    logic                   pend_valid;
    logic [ADDR_W-1:0]      pend_addr;
    logic [DATA_W-1:0]      pend_data;
    logic [DATA_W-1:0]      wr_count;

    assign tog_s = sync_q[SYNC_STAGES-1];

    // Edges are ignored until the sync chain and toggle_prev have both been
    // refilled from the live toggle, so a toggle left at 1 across reset
    // cannot masquerade as a write.
    assign wr_event = armed & (tog_s != toggle_prev);

    // NOTE: every register in this block uses non-blocking assignments so
    // all state updates see the pre-edge values, exactly like real flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            toggle_prev  <= 1'b0;
            arm_cnt      <= '0;
            armed        <= 1'b0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            wr_count     <= '0;
            reg_wr_pulse <= 1'b0;
            wr_err_pulse <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            // NOTE: the array is reset because software expects every
            // register to read 0 after reset; this costs a reset input on
            // each flop, so the array maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], wr_toggle_in};
            toggle_prev <= tog_s;

            if (!armed) begin
                if (arm_cnt == ARM_W'(ARM_CYCLES - 1)) begin
                    armed <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + ARM_W'(1);
                end
            end

            // Address/data have been stable for at least SYNC_STAGES cycles
            // by the time the synchronized edge appears, so they are sampled
            // here without their own synchronizer.
            pend_valid <= wr_event;
            if (wr_event) begin
                pend_addr <= wr_addr_in;
                pend_data <= wr_data_in;
            end

            reg_wr_pulse <= 1'b0;
            wr_err_pulse <= 1'b0;
            if (pend_valid) begin
                reg_wr_addr <= pend_addr;
                reg_wr_data <= pend_data;
                if (pend_addr < CNT_ADDR_V) begin
                    mem[pend_addr] <= pend_data;
                    wr_count       <= wr_count + DATA_W'(1);
                    reg_wr_pulse   <= 1'b1;
                end else begin
                    wr_err_pulse   <= 1'b1;
                end
            end
        end
    end

    // NOTE: rd_data gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_data = mem[rd_addr];
        if (rd_addr == CNT_ADDR_V) begin
            rd_data = wr_count;
        end else if (rd_addr == STAT_ADDR_V) begin
            rd_data = hw_status;
        end
    end

    for (genvar n = 0; n < DEPTH; n++) begin : g_flat
        if (n == CNT_ADDR) begin : g_cnt
            assign regs_flat[n*DATA_W +: DATA_W] = wr_count;
        end else if (n == STAT_ADDR) begin : g_stat
            assign regs_flat[n*DATA_W +: DATA_W] = hw_status;
        end else begin : g_reg
            assign regs_flat[n*DATA_W +: DATA_W] = mem[n];
        end
    end

endmodule

// File: tb/tb_spi_regfile_sync.sv
// ---------------------------------------------------------------------------
// tb_spi_regfile_sync
//
// Self-checking bench for spi_regfile_sync. A behavioural model (plain
// array plus write counter) tracks what the register bank must contain;
// a negedge monitor records every reg_wr_pulse / wr_err_pulse into queues.
// ---------------------------------------------------------------------------
module tb_spi_regfile_sync;

    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 2 ** ADDR_W;
    localparam int FLAT_W      = DEPTH * DATA_W;
    localparam int LATENCY     = SYNC_STAGES + 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [ADDR_W-1:0]     wr_addr_in = '0;
    logic [DATA_W-1:0]     wr_data_in = '0;
    logic                  wr_toggle_in = 1'b0;
    logic [ADDR_W-1:0]     rd_addr = '0;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     hw_status = '0;
    logic                  reg_wr_pulse;
    logic [ADDR_W-1:0]     reg_wr_addr;
    logic [DATA_W-1:0]     reg_wr_data;
    logic                  wr_err_pulse;
    logic [FLAT_W-1:0]     regs_flat;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] m_cnt;

    // Observed events: {addr, data}
    logic [ADDR_W+DATA_W-1:0] pulse_q [$];
    logic [ADDR_W+DATA_W-1:0] err_q   [$];

    spi_regfile_sync #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_addr_in   (wr_addr_in),
        .wr_data_in   (wr_data_in),
        .wr_toggle_in (wr_toggle_in),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .hw_status    (hw_status),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .wr_err_pulse (wr_err_pulse),
        .regs_flat    (regs_flat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_pulse) pulse_q.push_back({reg_wr_addr, reg_wr_data});
        if (wr_err_pulse) err_q.push_back({reg_wr_addr, reg_wr_data});
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt = '0;
    endtask

    // Applies the specification's write rule; returns 1 if the write is rejected.
    function automatic bit model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (int'(a) >= DEPTH - 2) return 1'b1;
        m_mem[a] = d;
        m_cnt    = m_cnt + 8'd1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input int a);
        if (a == DEPTH - 2) return m_cnt;
        if (a == DEPTH - 1) return hw_status;
        return m_mem[a];
    endfunction

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*DATA_W +: DATA_W] = model_read(i);
        return f;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse_q.delete();
        err_q.delete();
        model_clear();
        repeat (SYNC_STAGES + 3) @(negedge clk);
    endtask

    // Issues one bridge write and then idles for gap cycles.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
        @(negedge clk);
        wr_addr_in   = a;
        wr_data_in   = d;
        wr_toggle_in = ~wr_toggle_in;
        repeat (gap) @(negedge clk);
    endtask

    task automatic read_at(input int a, output logic [DATA_W-1:0] v);
        rd_addr = ADDR_W'(a);
        #1;
        v = rd_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [DATA_W-1:0] v;
        hw_status    = 8'h00;
        wr_toggle_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse_q.delete();
        err_q.delete();
        model_clear();
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_q.size() + err_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_pulse: got %0d events, required 0", pulse_q.size() + err_q.size());
        end
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_count: got %h, required 00", v);
        end
        checks++;
        if (regs_flat !== '0) begin
            errors++;
            $display("FAIL reset_flat: regs_flat not all zero, got %h", regs_flat);
        end
        checks++;
        if (reg_wr_addr !== '0 || reg_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_last_wr: got %h/%h, required 00/00", reg_wr_addr, reg_wr_data);
        end
    endtask

    task automatic test_single_write();
        int lat = 0;
        logic [DATA_W-1:0] v;
        bit rej;
        @(negedge clk);
        wr_addr_in   = 6'h05;
        wr_data_in   = 8'hA5;
        wr_toggle_in = ~wr_toggle_in;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (reg_wr_pulse && lat == 0) lat = c;
        end
        @(negedge clk);
        rej = model_write(6'h05, 8'hA5);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, required %0d", lat, LATENCY);
        end
        checks++;
        if (pulse_q.size() !== 1 || err_q.size() !== 0 || rej) begin
            errors++;
            $display("FAIL single_pulse_count: got %0d pulses %0d errs, required 1/0",
                     pulse_q.size(), err_q.size());
        end
        checks++;
        if (reg_wr_addr !== 6'h05 || reg_wr_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_last_wr: got %h/%h, required 05/a5", reg_wr_addr, reg_wr_data);
        end
        read_at(5, v);
        checks++;
        if (v !== model_read(5)) begin
            errors++;
            $display("FAIL single_rd_data: got %h, required %h", v, model_read(5));
        end
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== m_cnt) begin
            errors++;
            $display("FAIL single_count: got %h, required %h", v, m_cnt);
        end
    endtask

    task automatic test_readonly();
        logic [DATA_W-1:0] v;
        bit rej;
        hw_status = 8'h5C;
        pulse_q.delete();
        err_q.delete();
        do_write(6'h3F, 8'h12, 8);
        rej = model_write(6'h3F, 8'h12);
        do_write(6'h3E, 8'h34, 8);
        rej = model_write(6'h3E, 8'h34);
        checks++;
        if (err_q.size() !== 2 || pulse_q.size() !== 0) begin
            errors++;
            $display("FAIL ro_events: got %0d errs %0d pulses, required 2/0", err_q.size(), pulse_q.size());
        end
        checks++;
        if (reg_wr_addr !== 6'h3E || reg_wr_data !== 8'h34) begin
            errors++;
            $display("FAIL ro_last_wr: got %h/%h, required 3e/34", reg_wr_addr, reg_wr_data);
        end
        read_at(DEPTH - 1, v);
        checks++;
        if (v !== 8'h5C) begin
            errors++;
            $display("FAIL ro_status: got %h, required 5c", v);
        end
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL ro_count: got %h, required 01", v);
        end
        checks++;
        if (regs_flat !== model_flat()) begin
            errors++;
            $display("FAIL ro_flat: got %h, required %h", regs_flat, model_flat());
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] v;
        logic [ADDR_W+DATA_W-1:0] exp_q [$];
        bit rej;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_write(ADDR_W'(i), 8'h10 + DATA_W'(i), SYNC_STAGES + 3);
            rej = model_write(ADDR_W'(i), 8'h10 + DATA_W'(i));
            exp_q.push_back({ADDR_W'(i), 8'h10 + DATA_W'(i)});
        end
        repeat (8) @(negedge clk);
        checks++;
        if (pulse_q.size() !== 4) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d, required 4", pulse_q.size());
        end
        for (int i = 0; i < 4 && i < pulse_q.size(); i++) begin
            checks++;
            if (pulse_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %h, required %h", i, pulse_q[i], exp_q[i]);
            end
        end
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== 8'h04) begin
            errors++;
            $display("FAIL b2b_count: got %h, required 04", v);
        end
        checks++;
        if (regs_flat !== model_flat()) begin
            errors++;
            $display("FAIL b2b_flat: got %h, required %h", regs_flat, model_flat());
        end
    endtask

    task automatic test_counter_wrap();
        logic [DATA_W-1:0] v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit rej;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 3));
            d = DATA_W'($urandom);
            do_write(a, d, 6);
            rej = model_write(a, d);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (pulse_q.size() !== 256) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d, required 256", pulse_q.size());
        end
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL wrap_count_256: got %h, required 00", v);
        end
        checks++;
        if (regs_flat !== model_flat()) begin
            errors++;
            $display("FAIL wrap_flat: got %h, required %h", regs_flat, model_flat());
        end
        do_write(6'h11, 8'h3C, 8);
        rej = model_write(6'h11, 8'h3C);
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL wrap_count_257: got %h, required 01", v);
        end
    endtask

    task automatic test_mid_reset();
        logic [DATA_W-1:0] v;
        bit rej;
        apply_reset();
        @(negedge clk);
        wr_addr_in   = 6'h20;
        wr_data_in   = 8'h77;
        wr_toggle_in = ~wr_toggle_in;
        // Edge reaches tog_s after posedge SYNC_STAGES, is captured on the
        // next posedge; reset is raised before the commit edge.
        repeat (SYNC_STAGES + 1) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (SYNC_STAGES + 12) @(negedge clk);
        checks++;
        if (pulse_q.size() + err_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_events: got %0d, required 0", pulse_q.size() + err_q.size());
        end
        read_at(6'h20, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL midrst_target: got %h, required 00", v);
        end
        read_at(DEPTH - 2, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL midrst_count: got %h, required 00", v);
        end
        do_write(6'h20, 8'h99, 8);
        rej = model_write(6'h20, 8'h99);
        read_at(6'h20, v);
        checks++;
        if (v !== model_read(32) || pulse_q.size() !== 1) begin
            errors++;
            $display("FAIL midrst_recover: got %h with %0d pulses, required %h with 1",
                     v, pulse_q.size(), model_read(32));
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] v;
        int ra;
        bit rej;
        for (int i = 0; i < 40; i++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            d = DATA_W'($urandom);
            hw_status = DATA_W'($urandom);
            pulse_q.delete();
            err_q.delete();
            do_write(a, d, 7);
            rej = model_write(a, d);
            checks++;
            if (pulse_q.size() !== (rej ? 0 : 1) || err_q.size() !== (rej ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_events[%0d] addr %h: got %0d pulses %0d errs, required %0d/%0d",
                         i, a, pulse_q.size(), err_q.size(), rej ? 0 : 1, rej ? 1 : 0);
            end
            ra = (i % 2 == 0) ? int'(a) : int'($urandom_range(0, DEPTH - 1));
            read_at(ra, v);
            checks++;
            if (v !== model_read(ra)) begin
                errors++;
                $display("FAIL rand_read[%0d] addr %0d: got %h, required %h", i, ra, v, model_read(ra));
            end
        end
        checks++;
        if (regs_flat !== model_flat()) begin
            errors++;
            $display("FAIL rand_flat: got %h, required %h", regs_flat, model_flat());
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_write();
        test_readonly();
        test_back_to_back();
        test_counter_wrap();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
